// File: rtl/plc_seq_axil_regs.sv
// AXI4-Lite slave holding four 32-bit control registers for the PLC sequencer core.
// The write (AW/W/B) and read (AR/R) channels run as independent FSMs with full backpressure.
module plc_seq_axil_regs #(
  parameter int          C_S_AXI_DATA_WIDTH = 32,
  parameter int          C_S_AXI_ADDR_WIDTH = 4,
  parameter logic [31:0] C_RST_VAL          = 32'h0
) (
  input  logic                              ACLK,
  input  logic                              ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [2:0]                        S_AXI_AWPROT,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [2:0]                        S_AXI_ARPROT,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY,
  output logic [31:0]                       reg0_o,
  output logic [31:0]                       reg1_o,
  output logic [31:0]                       reg2_o,
  output logic [31:0]                       reg3_o,
  output logic [3:0]                        reg_wr_stb_o
);

  typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} wr_state_t;
  typedef enum logic {R_IDLE, R_DATA} rd_state_t;

  wr_state_t        wr_state_reg, wr_state_next;
  rd_state_t        rd_state_reg, rd_state_next;
  logic             ready_en_reg;
  logic [1:0]       awaddr_reg;
  logic [31:0]      wdata_reg;
  logic [3:0]       wstrb_reg;
  logic [3:0][31:0] regs_reg;
  logic [31:0]      rdata_reg;
  logic [3:0]       wr_stb_reg;
  logic             aw_hs, w_hs, ar_hs, commit;
  logic [1:0]       wr_sel;
  logic [31:0]      wr_data, wr_merge;
  logic [3:0]       wr_strb;

  wire unused_ok = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // Holds the READYs low while in reset and for the edge that releases it.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) ready_en_reg <= 1'b0;
    else        ready_en_reg <= 1'b1;
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      wr_state_reg <= W_IDLE;
      rd_state_reg <= R_IDLE;
    end else begin
      wr_state_reg <= wr_state_next;
      rd_state_reg <= rd_state_next;
    end
  end

  always_comb begin
    wr_state_next = wr_state_reg;
    S_AXI_AWREADY = 1'b0;
    S_AXI_WREADY  = 1'b0;
    S_AXI_BVALID  = 1'b0;
    commit        = 1'b0;
    case (wr_state_reg)
      W_IDLE: begin
        S_AXI_AWREADY = ready_en_reg;
        S_AXI_WREADY  = ready_en_reg;
        if (ready_en_reg && S_AXI_AWVALID && S_AXI_WVALID) begin
          commit        = 1'b1;
          wr_state_next = W_RESP;
        end else if (ready_en_reg && S_AXI_AWVALID) begin
          wr_state_next = W_HAVE_AW;
        end else if (ready_en_reg && S_AXI_WVALID) begin
          wr_state_next = W_HAVE_W;
        end
      end
      W_HAVE_AW: begin
        S_AXI_WREADY = 1'b1;
        if (S_AXI_WVALID) begin
          commit        = 1'b1;
          wr_state_next = W_RESP;
        end
      end
      W_HAVE_W: begin
        S_AXI_AWREADY = 1'b1;
        if (S_AXI_AWVALID) begin
          commit        = 1'b1;
          wr_state_next = W_RESP;
        end
      end
      W_RESP: begin
        S_AXI_BVALID = 1'b1;
        if (S_AXI_BREADY) wr_state_next = W_IDLE;
      end
      default: wr_state_next = W_IDLE;
    endcase
  end

  always_comb begin
    rd_state_next = rd_state_reg;
    S_AXI_ARREADY = 1'b0;
    S_AXI_RVALID  = 1'b0;
    case (rd_state_reg)
      R_IDLE: begin
        S_AXI_ARREADY = ready_en_reg;
        if (ready_en_reg && S_AXI_ARVALID) rd_state_next = R_DATA;
      end
      R_DATA: begin
        S_AXI_RVALID = 1'b1;
        if (S_AXI_RREADY) rd_state_next = R_IDLE;
      end
      default: rd_state_next = R_IDLE;
    endcase
  end

  assign aw_hs = S_AXI_AWVALID & S_AXI_AWREADY;
  assign w_hs  = S_AXI_WVALID  & S_AXI_WREADY;
  assign ar_hs = S_AXI_ARVALID & S_AXI_ARREADY;

  // Whichever half arrived earlier comes from its holding register, the other is live.
  assign wr_sel  = (wr_state_reg == W_HAVE_AW) ? awaddr_reg : S_AXI_AWADDR[3:2];
  assign wr_data = (wr_state_reg == W_HAVE_W)  ? wdata_reg  : S_AXI_WDATA[31:0];
  assign wr_strb = (wr_state_reg == W_HAVE_W)  ? wstrb_reg  : S_AXI_WSTRB[3:0];

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_merge
      assign wr_merge[8*gi +: 8] = wr_strb[gi] ? wr_data[8*gi +: 8] : regs_reg[wr_sel][8*gi +: 8];
    end
  endgenerate

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      awaddr_reg <= 2'b00;
      wdata_reg  <= 32'h0;
      wstrb_reg  <= 4'h0;
      regs_reg   <= {4{C_RST_VAL}};
      rdata_reg  <= 32'h0;
      wr_stb_reg <= 4'h0;
    end else begin
      wr_stb_reg <= 4'h0;
      if (aw_hs) awaddr_reg <= S_AXI_AWADDR[3:2];
      if (w_hs) begin
        wdata_reg <= S_AXI_WDATA[31:0];
        wstrb_reg <= S_AXI_WSTRB[3:0];
      end
      if (commit) begin
        regs_reg[wr_sel]   <= wr_merge;
        wr_stb_reg[wr_sel] <= 1'b1;
      end
      // Same-edge read of a register being written returns the pre-write value.
      if (ar_hs) rdata_reg <= regs_reg[S_AXI_ARADDR[3:2]];
    end
  end

  assign S_AXI_BRESP  = 2'b00;
  assign S_AXI_RRESP  = 2'b00;
  assign S_AXI_RDATA  = rdata_reg;
  assign reg0_o       = regs_reg[0];
  assign reg1_o       = regs_reg[1];
  assign reg2_o       = regs_reg[2];
  assign reg3_o       = regs_reg[3];
  assign reg_wr_stb_o = wr_stb_reg;

endmodule

// File: tb/tb_plc_seq_axil_regs.sv
// Directed self-checking bench for plc_seq_axil_regs; inputs change and outputs are
// sampled 1 ns after each rising edge.
module tb_plc_seq_axil_regs;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [3:0]  S_AXI_AWADDR;
  logic [2:0]  S_AXI_AWPROT;
  logic        S_AXI_AWVALID;
  logic        S_AXI_AWREADY;
  logic [31:0] S_AXI_WDATA;
  logic [3:0]  S_AXI_WSTRB;
  logic        S_AXI_WVALID;
  logic        S_AXI_WREADY;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_BVALID;
  logic        S_AXI_BREADY;
  logic [3:0]  S_AXI_ARADDR;
  logic [2:0]  S_AXI_ARPROT;
  logic        S_AXI_ARVALID;
  logic        S_AXI_ARREADY;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        S_AXI_RVALID;
  logic        S_AXI_RREADY;
  logic [31:0] reg0_o, reg1_o, reg2_o, reg3_o;
  logic [3:0]  reg_wr_stb_o;

  int vectors     = 0;
  int miscompares = 0;

  always #5 ACLK = ~ACLK;

  plc_seq_axil_regs dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .reg0_o(reg0_o), .reg1_o(reg1_o), .reg2_o(reg2_o), .reg3_o(reg3_o),
    .reg_wr_stb_o(reg_wr_stb_o)
  );

  // Full AW+W write, then B handshake; starts and ends 1 ns after a rising edge.
  task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp, output logic [3:0] stb_commit,
                           output logic [3:0] stb_after);
    int   n;
    logic aw_done, w_done, awr, wr;
    n = 0; aw_done = 1'b0; w_done = 1'b0;
    S_AXI_AWADDR = a; S_AXI_AWVALID = 1'b1;
    S_AXI_WDATA = d; S_AXI_WSTRB = s; S_AXI_WVALID = 1'b1;
    while (!(aw_done && w_done) && n < 20) begin
      awr = S_AXI_AWREADY; wr = S_AXI_WREADY;
      @(posedge ACLK); #1; n++;
      if (S_AXI_AWVALID && awr) begin aw_done = 1'b1; S_AXI_AWVALID = 1'b0; end
      if (S_AXI_WVALID && wr) begin w_done = 1'b1; S_AXI_WVALID = 1'b0; end
    end
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    vectors++;
    if (!(aw_done && w_done)) begin
      miscompares++;
      $display("FAIL wr_handshake addr=%h: aw=%0b w=%0b required both 1", a, aw_done, w_done);
    end
    stb_commit = reg_wr_stb_o;
    n = 0;
    while (!S_AXI_BVALID && n < 20) begin @(posedge ACLK); #1; n++; end
    vectors++;
    if (S_AXI_BVALID !== 1'b1) begin
      miscompares++;
      $display("FAIL wr_bvalid addr=%h: got %b required 1", a, S_AXI_BVALID);
    end
    resp = S_AXI_BRESP;
    S_AXI_BREADY = 1'b1;
    @(posedge ACLK); #1;
    S_AXI_BREADY = 1'b0;
    stb_after = reg_wr_stb_o;
    $display("write addr=%h data=%h strb=%b bresp=%b", a, d, s, resp);
  endtask

  task automatic axi_read(input logic [3:0] a, output logic [31:0] data, output logic [1:0] resp);
    int   n;
    logic arr, done;
    n = 0; done = 1'b0;
    S_AXI_ARADDR = a; S_AXI_ARVALID = 1'b1;
    while (!done && n < 20) begin
      arr = S_AXI_ARREADY;
      @(posedge ACLK); #1; n++;
      if (arr) done = 1'b1;
    end
    S_AXI_ARVALID = 1'b0;
    vectors++;
    if (S_AXI_RVALID !== 1'b1) begin
      miscompares++;
      $display("FAIL rd_rvalid addr=%h: got %b required 1", a, S_AXI_RVALID);
    end
    data = S_AXI_RDATA; resp = S_AXI_RRESP;
    S_AXI_RREADY = 1'b1;
    @(posedge ACLK); #1;
    S_AXI_RREADY = 1'b0;
    $display("read  addr=%h rdata=%h rresp=%b", a, data, resp);
  endtask

  task automatic test_reset();
    ARESET = 1'b1;
    repeat (2) @(posedge ACLK);
    #1;
    vectors++;
    if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_readys: got %b required 000", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY});
    end
    vectors++;
    if ({S_AXI_BVALID, S_AXI_RVALID, reg_wr_stb_o} !== 6'b0 || S_AXI_RDATA !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_outs: bv/rv/stb=%b rdata=%h required 0", {S_AXI_BVALID, S_AXI_RVALID, reg_wr_stb_o}, S_AXI_RDATA);
    end
    vectors++;
    if ({reg0_o, reg1_o, reg2_o, reg3_o} !== 128'h0) begin
      miscompares++;
      $display("FAIL reset_regs: got %h %h %h %h required 0", reg0_o, reg1_o, reg2_o, reg3_o);
    end
    @(negedge ACLK); ARESET = 1'b0;
    @(posedge ACLK); #1;
    vectors++;
    if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY} !== 3'b111) begin
      miscompares++;
      $display("FAIL release_readys: got %b required 111", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY});
    end
    $display("reset sequence done");
  endtask

  task automatic test_write_read();
    logic [1:0]  resp;
    logic [3:0]  sc, sa;
    logic [31:0] rd;
    for (int i = 0; i < 4; i++) begin
      axi_write(4'(4 * i), 32'(i + 1), 4'hF, resp, sc, sa);
      vectors++;
      if (resp !== 2'b00) begin
        miscompares++;
        $display("FAIL wr_bresp reg%0d: got %b required 00", i, resp);
      end
    end
    for (int i = 0; i < 4; i++) begin
      axi_read(4'(4 * i), rd, resp);
      vectors++;
      if (rd !== 32'(i + 1) || resp !== 2'b00) begin
        miscompares++;
        $display("FAIL readback reg%0d: got %h/%b required %h/00", i, rd, resp, 32'(i + 1));
      end
    end
  endtask

  task automatic test_strobe();
    logic [1:0]  resp;
    logic [3:0]  sc, sa;
    logic [31:0] rd;
    axi_write(4'h4, 32'hFFFF_FFFF, 4'hF, resp, sc, sa);
    axi_write(4'h4, 32'h1234_5678, 4'b0101, resp, sc, sa);
    vectors++;
    if (sc !== 4'b0010 || sa !== 4'b0000) begin
      miscompares++;
      $display("FAIL strobe_pulse: got %b then %b required 0010 then 0000", sc, sa);
    end
    vectors++;
    if (reg1_o !== 32'hFF34_FF78) begin
      miscompares++;
      $display("FAIL strobe_reg1: got %h required ff34ff78", reg1_o);
    end
    axi_read(4'h4, rd, resp);
    vectors++;
    if (rd !== 32'hFF34_FF78) begin
      miscompares++;
      $display("FAIL strobe_read: got %h required ff34ff78", rd);
    end
  endtask

  task automatic test_zero_strobe();
    logic [1:0] resp;
    logic [3:0] sc, sa;
    axi_write(4'hC, 32'hFFFF_FFFF, 4'b0000, resp, sc, sa);
    vectors++;
    if (resp !== 2'b00 || sc !== 4'b1000 || reg3_o !== 32'h4) begin
      miscompares++;
      $display("FAIL zero_strobe: resp=%b stb=%b reg3=%h required 00/1000/00000004", resp, sc, reg3_o);
    end
  endtask

  task automatic test_w_before_aw();
    logic [1:0]  resp;
    logic [31:0] rd;
    S_AXI_WDATA = 32'hA5A5_A5A5; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
    @(posedge ACLK); #1;
    S_AXI_WVALID = 1'b0;
    vectors++;
    if ({S_AXI_WREADY, S_AXI_AWREADY} !== 2'b01) begin
      miscompares++;
      $display("FAIL w_first_readys: wready/awready=%b required 01", {S_AXI_WREADY, S_AXI_AWREADY});
    end
    repeat (2) begin
      @(posedge ACLK); #1;
      vectors++;
      if (S_AXI_BVALID !== 1'b0 || reg2_o !== 32'h3) begin
        miscompares++;
        $display("FAIL w_first_hold: bvalid=%b reg2=%h required 0/00000003", S_AXI_BVALID, reg2_o);
      end
    end
    S_AXI_AWADDR = 4'h8; S_AXI_AWVALID = 1'b1;
    @(posedge ACLK); #1;
    S_AXI_AWVALID = 1'b0;
    vectors++;
    if (S_AXI_BVALID !== 1'b1 || reg2_o !== 32'hA5A5_A5A5 || reg_wr_stb_o !== 4'b0100) begin
      miscompares++;
      $display("FAIL w_first_commit: bvalid=%b reg2=%h stb=%b required 1/a5a5a5a5/0100", S_AXI_BVALID, reg2_o, reg_wr_stb_o);
    end
    S_AXI_BREADY = 1'b1;
    @(posedge ACLK); #1;
    S_AXI_BREADY = 1'b0;
    axi_read(4'h8, rd, resp);
    vectors++;
    if (rd !== 32'hA5A5_A5A5) begin
      miscompares++;
      $display("FAIL w_first_read: got %h required a5a5a5a5", rd);
    end
  endtask

  task automatic test_bready_stall();
    S_AXI_AWADDR = 4'h0; S_AXI_WDATA = 32'hCAFE_0001; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    @(posedge ACLK); #1;
    vectors++;
    if (S_AXI_BVALID !== 1'b1 || reg0_o !== 32'hCAFE_0001) begin
      miscompares++;
      $display("FAIL stall_first: bvalid=%b reg0=%h required 1/cafe0001", S_AXI_BVALID, reg0_o);
    end
    S_AXI_WDATA = 32'hDEAD_BEEF;
    for (int i = 0; i < 10; i++) begin
      vectors++;
      if ({S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY} !== 3'b100 || reg0_o !== 32'hCAFE_0001) begin
        miscompares++;
        $display("FAIL stall_cycle%0d: bv/awr/wr=%b reg0=%h required 100/cafe0001", i,
                 {S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY}, reg0_o);
      end
      @(posedge ACLK); #1;
    end
    S_AXI_BREADY = 1'b1;
    @(posedge ACLK); #1;
    vectors++;
    if ({S_AXI_BVALID, S_AXI_AWREADY} !== 2'b01 || reg0_o !== 32'hCAFE_0001) begin
      miscompares++;
      $display("FAIL stall_release: bv/awr=%b reg0=%h required 01/cafe0001", {S_AXI_BVALID, S_AXI_AWREADY}, reg0_o);
    end
    @(posedge ACLK); #1;
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    vectors++;
    if (S_AXI_BVALID !== 1'b1 || reg0_o !== 32'hDEAD_BEEF) begin
      miscompares++;
      $display("FAIL stall_second: bvalid=%b reg0=%h required 1/deadbeef", S_AXI_BVALID, reg0_o);
    end
    @(posedge ACLK); #1;
    S_AXI_BREADY = 1'b0;
    $display("stalled write pair done");
  endtask

  task automatic test_same_edge();
    logic [1:0]  resp;
    logic [3:0]  sc, sa;
    logic [31:0] rd;
    axi_write(4'h4, 32'h2, 4'hF, resp, sc, sa);
    S_AXI_AWADDR = 4'h4; S_AXI_WDATA = 32'h55; S_AXI_WSTRB = 4'hF;
    S_AXI_ARADDR = 4'h4;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_ARVALID = 1'b1;
    @(posedge ACLK); #1;
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_ARVALID = 1'b0;
    vectors++;
    if (S_AXI_RVALID !== 1'b1 || S_AXI_RDATA !== 32'h2) begin
      miscompares++;
      $display("FAIL same_edge_rdata: rvalid=%b rdata=%h required 1/00000002", S_AXI_RVALID, S_AXI_RDATA);
    end
    vectors++;
    if (S_AXI_BVALID !== 1'b1 || reg1_o !== 32'h55) begin
      miscompares++;
      $display("FAIL same_edge_write: bvalid=%b reg1=%h required 1/00000055", S_AXI_BVALID, reg1_o);
    end
    S_AXI_RREADY = 1'b1; S_AXI_BREADY = 1'b1;
    @(posedge ACLK); #1;
    S_AXI_RREADY = 1'b0; S_AXI_BREADY = 1'b0;
    axi_read(4'h4, rd, resp);
    vectors++;
    if (rd !== 32'h55) begin
      miscompares++;
      $display("FAIL same_edge_next_read: got %h required 00000055", rd);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  addrs [3];
    logic [31:0] datas [3];
    logic [3:0]  stbs  [3];
    logic [31:0] got;
    addrs = '{4'h0, 4'h0 + 4'h0, 4'h4};
    addrs[1] = 4'h0;
    datas = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333};
    stbs  = '{4'b0001, 4'b0001, 4'b0010};
    S_AXI_BREADY = 1'b1; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    for (int k = 0; k < 3; k++) begin
      S_AXI_AWADDR = (k == 1) ? 4'h0 : addrs[k];
      S_AXI_WDATA  = datas[k];
      @(posedge ACLK); #1;
      got = (stbs[k] == 4'b0010) ? reg1_o : reg0_o;
      vectors++;
      if (S_AXI_BVALID !== 1'b1 || reg_wr_stb_o !== stbs[k] || got !== datas[k]) begin
        miscompares++;
        $display("FAIL b2b_commit%0d: bvalid=%b stb=%b reg=%h required 1/%b/%h", k,
                 S_AXI_BVALID, reg_wr_stb_o, got, stbs[k], datas[k]);
      end
      if (k == 2) begin S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0; end
      @(posedge ACLK); #1;
      vectors++;
      if (S_AXI_BVALID !== 1'b0) begin
        miscompares++;
        $display("FAIL b2b_idle%0d: bvalid=%b required 0", k, S_AXI_BVALID);
      end
      $display("back-to-back write %0d data=%h", k, datas[k]);
    end
    S_AXI_BREADY = 1'b0;
  endtask

  task automatic test_alias();
    logic [1:0] resp;
    logic [3:0] sc, sa;
    axi_write(4'h0, 32'h0, 4'hF, resp, sc, sa);
    // 4-bit bus: an address of 0x10 truncates to 0x0, so alias is checked via byte offset bits
    axi_write(4'h3, 32'h0BAD_F00D, 4'hF, resp, sc, sa);
    vectors++;
    if (reg0_o !== 32'h0BAD_F00D || sc !== 4'b0001) begin
      miscompares++;
      $display("FAIL alias_low_bits: reg0=%h stb=%b required 0badf00d/0001", reg0_o, sc);
    end
  endtask

  task automatic test_reset_mid();
    S_AXI_WDATA = 32'h77; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b1;
    @(posedge ACLK); #1;
    S_AXI_WVALID = 1'b0;
    #1 ARESET = 1'b1;
    #1;
    vectors++;
    if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID, reg_wr_stb_o} !== 8'h0 || S_AXI_RDATA !== 32'h0) begin
      miscompares++;
      $display("FAIL midreset_outs: readys/bv/stb=%b rdata=%h required 0",
               {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID, reg_wr_stb_o}, S_AXI_RDATA);
    end
    vectors++;
    if ({reg0_o, reg1_o, reg2_o, reg3_o} !== 128'h0) begin
      miscompares++;
      $display("FAIL midreset_regs: got %h %h %h %h required 0", reg0_o, reg1_o, reg2_o, reg3_o);
    end
    @(posedge ACLK);
    @(negedge ACLK); ARESET = 1'b0;
    S_AXI_AWADDR = 4'h8; S_AXI_AWVALID = 1'b1;
    @(posedge ACLK); #1;
    vectors++;
    if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY} !== 3'b111) begin
      miscompares++;
      $display("FAIL midreset_release: readys=%b required 111", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY});
    end
    @(posedge ACLK); #1;
    S_AXI_AWVALID = 1'b0;
    repeat (3) begin
      vectors++;
      if (S_AXI_BVALID !== 1'b0 || reg2_o !== 32'h0) begin
        miscompares++;
        $display("FAIL midreset_no_commit: bvalid=%b reg2=%h required 0/00000000", S_AXI_BVALID, reg2_o);
      end
      @(posedge ACLK); #1;
    end
    $display("mid-transaction reset done");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ARESET = 1'b1;
    S_AXI_AWADDR = '0; S_AXI_AWPROT = '0; S_AXI_AWVALID = 1'b0;
    S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b0;
    S_AXI_ARADDR = '0; S_AXI_ARPROT = '0; S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b0;
    test_reset();
    test_write_read();
    test_strobe();
    test_zero_strobe();
    test_w_before_aw();
    test_bready_stall();
    test_same_edge();
    test_back_to_back();
    test_alias();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
